fsm_mealy_moore: RTL and testbench

FSM_MEALY_MOORE -- requirements
Module: fsm_mealy_moore

---
 rtl/fsm_mealy_moore_pkg.sv | 30 +++
 rtl/fsm_mealy_moore_seq_moore_core.sv | 51 +++++
 rtl/fsm_mealy_moore.sv | 89 ++++++++
 tb/tb_fsm_mealy_moore.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_mealy_moore_pkg.sv
// -----------------------------------------------------------------------------
// fsm_mealy_moore_pkg
//   Shared types for the consecutive-ones detector pair.
//   - MAX_RUN_LEN   : largest supported run length.
//   - moore_state_e : Moore states S0..S4, encoded as the count of consecutive 1s.
//   - mealy_state_e : Mealy states M0..M3, encoded as the count of consecutive 1s.
//   Both enums are sized for MAX_RUN_LEN. Builds with a smaller RUN_LEN leave
//   some encodings unused, and the machines treat those encodings as illegal.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package fsm_mealy_moore_pkg;

   localparam int MAX_RUN_LEN = 4;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } moore_state_e;

   typedef enum logic [1:0] {
      M0 = 2'd0,
      M1 = 2'd1,
      M2 = 2'd2,
      M3 = 2'd3
   } mealy_state_e;

endpackage

// File: rtl/fsm_mealy_moore_seq_moore_core.sv
// -----------------------------------------------------------------------------
// seq_moore_core
//   Moore detector for RUN_LEN consecutive 1s on a serial input.
//   The state counts consecutive 1s and saturates at S_RUN_LEN. The output is
//   asserted only in state S_RUN_LEN.
//   Ports:
//     clk     : clock; the state updates on the rising edge.
//     reset   : asynchronous reset, active low.
//     x       : serial data bit.
//     q_moore : detector output, registered.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module seq_moore_core
   import fsm_mealy_moore_pkg::*;
#(
   parameter int RUN_LEN = 2   // legal range 2..MAX_RUN_LEN
) (
   input  logic clk,
   input  logic reset,
   input  logic x,
   output logic q_moore
);

   localparam moore_state_e S_RUN = moore_state_e'(3'(RUN_LEN));

   moore_state_e state_q, state_d;
   logic         q_moore_q;

   always_comb begin
      state_d = S0;
      // An encoding above S_RUN is unreachable; it falls back to S0.
      if (state_q <= S_RUN && x) begin
         state_d = (state_q == S_RUN) ? S_RUN : moore_state_e'(state_q + 3'd1);
      end
   end

   // The output register is loaded from a decode of the next state. As a
   // result it always equals (state_q == S_RUN) and depends on the state only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S0;
         q_moore_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         q_moore_q <= (state_d == S_RUN);
      end
   end

   assign q_moore = q_moore_q;

endmodule

// File: rtl/fsm_mealy_moore.sv
// -----------------------------------------------------------------------------
// fsm_mealy_moore
//   Consecutive-ones detector, built twice: once as a Moore machine
//   (seq_moore_core) and once as a Mealy machine with a registered output.
//   The two outputs are equal in every cycle.
//   Ports:
//     clk      : clock; all state updates on the rising edge.
//     reset    : asynchronous reset, active low.
//     x        : serial data bit, sampled on the rising edge.
//     q_moore  : Moore detector output.
//     q_mealy  : registered Mealy detector output.
//     mismatch : sticky flag, set when q_mealy and q_moore differ.
//   Configuration:
//     FSM_MEALY_MOORE_EQUIV_CHECK_EN : when defined, builds the equivalence
//     checker that drives mismatch. When undefined, mismatch is tied to 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fsm_mealy_moore
   import fsm_mealy_moore_pkg::*;
#(
   parameter int RUN_LEN = 2   // legal range 2..MAX_RUN_LEN
) (
   input  logic clk,
   input  logic reset,
   input  logic x,
   output logic q_moore,
   output logic q_mealy,
   output logic mismatch
);

   // The Mealy machine needs one state fewer than the Moore machine, because
   // the completing 1 is seen through the combinational term y.
   localparam mealy_state_e M_LAST = mealy_state_e'(2'(RUN_LEN - 1));

   mealy_state_e mealy_q, mealy_d;
   logic         y;
   logic         q_mealy_q;

   seq_moore_core #(
      .RUN_LEN (RUN_LEN)
   ) u_moore (
      .clk     (clk),
      .reset   (reset),
      .x       (x),
      .q_moore (q_moore)
   );

   assign y = (mealy_q == M_LAST) && x;

   always_comb begin
      mealy_d = M0;
      // An encoding above M_LAST is unreachable; it falls back to M0.
      if (mealy_q <= M_LAST && x) begin
         mealy_d = (mealy_q == M_LAST) ? M_LAST : mealy_state_e'(mealy_q + 2'd1);
      end
   end

   // y is registered on the same edge that samples x. This removes the Mealy
   // term's combinational dependence on x, so q_mealy lines up with q_moore.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mealy_q   <= M0;
         q_mealy_q <= 1'b0;
      end else begin
         mealy_q   <= mealy_d;
         q_mealy_q <= y;
      end
   end

   assign q_mealy = q_mealy_q;

`ifdef FSM_MEALY_MOORE_EQUIV_CHECK_EN
   logic mismatch_q;

   // Sticky flag: once set, it stays set until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mismatch_q <= 1'b0;
      end else if (q_mealy_q != q_moore) begin
         mismatch_q <= 1'b1;
      end
   end

   assign mismatch = mismatch_q;
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_mealy_moore.sv
`timescale 1ns/1ps
module tb_fsm_mealy_moore;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic x     = 1'b0;

   logic qmo2, qme2, mis2;
   logic qmo3, qme3, mis3;
   logic qmo4, qme4, mis4;

   always #5 clk = ~clk;

   fsm_mealy_moore #(.RUN_LEN(2)) dut2 (
      .clk(clk), .reset(reset), .x(x),
      .q_moore(qmo2), .q_mealy(qme2), .mismatch(mis2)
   );
   fsm_mealy_moore #(.RUN_LEN(3)) dut3 (
      .clk(clk), .reset(reset), .x(x),
      .q_moore(qmo3), .q_mealy(qme3), .mismatch(mis3)
   );
   fsm_mealy_moore #(.RUN_LEN(4)) dut4 (
      .clk(clk), .reset(reset), .x(x),
      .q_moore(qmo4), .q_mealy(qme4), .mismatch(mis4)
   );

   typedef struct packed {
      logic e2;
      logic e3;
      logic e4;
   } exp_t;

   exp_t exp_q[$];
   bit   hist[$];     // x values sampled since the last reset, newest at the back
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: output is 1 when the newest len samples are all 1.
   function automatic logic run_of_ones(int len);
      if (hist.size() < len) return 1'b0;
      for (int i = 0; i < len; i++)
         if (!hist[hist.size() - 1 - i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void check(string name, logic act, logic req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void compare_all(string tag, exp_t e);
      check({tag, " L2 q_moore"}, qmo2, e.e2);
      check({tag, " L2 q_mealy"}, qme2, e.e2);
      check({tag, " L2 mismatch"}, mis2, 1'b0);
      check({tag, " L3 q_moore"}, qmo3, e.e3);
      check({tag, " L3 q_mealy"}, qme3, e.e3);
      check({tag, " L3 mismatch"}, mis3, 1'b0);
      check({tag, " L4 q_moore"}, qmo4, e.e4);
      check({tag, " L4 q_mealy"}, qme4, e.e4);
      check({tag, " L4 mismatch"}, mis4, 1'b0);
   endfunction

   // Called at a falling edge. Drives x for the next rising edge, pushes the
   // expected response, and returns at the following falling edge.
   task automatic step(input logic xv);
      exp_t e;
      x = xv;
      if (reset) begin
         hist.push_back(xv);
         if (hist.size() > 8) void'(hist.pop_front());
      end
      e.e2 = reset && run_of_ones(2);
      e.e3 = reset && run_of_ones(3);
      e.e4 = reset && run_of_ones(4);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Short asynchronous reset pulse between edges. The clear must take effect
   // immediately, without waiting for the clock.
   task automatic pulse_reset();
      #2;
      reset = 1'b0;
      hist.delete();
      #1;
      compare_all("async reset", '0);
      #1;
      reset = 1'b1;
   endtask

   // Monitor: compares just after each rising edge. It compares again after x
   // has changed mid-cycle, to confirm the outputs held.
   exp_t cur;
   bit   cur_v = 1'b0;
   initial begin
      forever begin
         @(posedge clk);
         #1ps;
         cur_v = 1'b0;
         if (exp_q.size() > 0) begin
            cur   = exp_q.pop_front();
            cur_v = 1'b1;
            compare_all("edge", cur);
         end
         @(negedge clk);
         #1ps;
         if (cur_v) compare_all("hold", cur);
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq_a;
      logic [5:0] seq_b;
      seq_a = 8'b0001_1011;    // applied MSB first: 0,0,0,1,1,0,1,1
      seq_b = 6'b11_0111;      // applied MSB first: 1,1,0,1,1,1

      // Hold in reset across several edges while x is 1.
      reset = 1'b0;
      x     = 1'b1;
      @(negedge clk);
      compare_all("reset held", '0);
      step(1'b1);
      step(1'b1);

      // Release reset with x = 0.
      reset = 1'b1;
      step(1'b0);
      step(1'b0);

      for (int i = 7; i >= 0; i--) step(seq_a[i]);

      // Five edges with x held at 1.
      step(1'b0);
      for (int i = 0; i < 5; i++) step(1'b1);

      // A reset pulse between two 1s discards the partial run.
      step(1'b0);
      step(1'b1);
      pulse_reset();
      step(1'b1);
      step(1'b0);

      for (int i = 5; i >= 0; i--) step(seq_b[i]);
      step(1'b0);

      // Random traffic biased toward 1s so that runs of 4 occur, with
      // occasional reset pulses.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) pulse_reset();
         step(logic'($urandom_range(0, 3) != 0));
      end

      @(negedge clk);
      check("scoreboard drained", logic'(exp_q.size() == 0), 1'b1);

`ifdef FSM_MEALY_MOORE_EQUIV_CHECK_EN
      // Force a disagreement between the two detectors. Nothing is queued,
      // so the monitor stays idle during this section.
      x = 1'b0;
      @(negedge clk);
      @(negedge clk);
      force dut2.q_mealy_q = 1'b1;
      @(posedge clk);
      #1ps;
      release dut2.q_mealy_q;
      check("forced mismatch set", mis2, 1'b1);
      check("unforced L3 mismatch", mis3, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1ps;
      check("mismatch sticky", mis2, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mismatch cleared by reset", mis2, 1'b0);
      reset = 1'b1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
